seq_div_48by24: RTL and testbench

// - Sequential restoring divider; the inverse datapath of the 24-bit combinational multiplier.
// - Takes a 2*WIDTH-bit dividend (e.g. a multiplier Result) and a WIDTH-bit divisor.
// - Returns the quotient and remainder after 2*WIDTH iterations, one quotient bit per clock.
// - Sits beside the multiplier in the arithmetic unit and uses a start/done handshake.

---
 rtl/seq_div_48by24_pkg.sv | 10 +
 rtl/seq_div_48by24_div_step_unit.sv | 21 ++
 rtl/seq_div_48by24.sv | 94 +++++++++
 tb/tb_seq_div_48by24.sv | 102 ++++++++++
 4 files changed

// File: rtl/seq_div_48by24_pkg.sv
// Shared definitions for the sequential restoring divider: default width and FSM encoding.
package seq_div_48by24_pkg;
  localparam int DIV_WIDTH = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;
endpackage

// File: rtl/seq_div_48by24_div_step_unit.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
module div_step_unit
  import seq_div_48by24_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   i_p,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH:0]   o_p,
  output logic             o_qbit
);
  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  assign w_shift = {i_p[WIDTH-1:0], i_bit};
  assign w_diff  = w_shift - {1'b0, i_divisor};
  // A set top bit in P would shift out past WIDTH+1 bits, so the divisor always fits then.
  assign o_qbit  = i_p[WIDTH] | (w_shift >= {1'b0, i_divisor});
  assign o_p     = o_qbit ? w_diff : w_shift;
endmodule

// File: rtl/seq_div_48by24.sv
// Sequential restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor, one quotient bit per clock.
module seq_div_48by24
  import seq_div_48by24_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic [2*WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 busy,
  output logic                 done,
  output logic                 div_by_zero
);
  localparam int QW = 2 * WIDTH;
  localparam int CW = $clog2(QW);
  localparam logic [CW-1:0] LAST = CW'(QW - 1);

  div_state_e     r_state, w_state_nxt;
  logic [WIDTH:0] r_p, w_p_nxt;
  logic [QW-1:0]  r_q;
  logic [WIDTH-1:0] r_d;
  logic [CW-1:0]  r_cnt;
  logic           w_qbit, w_accept, w_last;

  div_step_unit #(.WIDTH(WIDTH)) u_step (
    .i_p      (r_p),
    .i_bit    (r_q[QW-1]),
    .i_divisor(r_d),
    .o_p      (w_p_nxt),
    .o_qbit   (w_qbit)
  );

  assign w_last = (r_cnt == LAST);
  assign busy   = (r_state == RUN);
  assign done   = (r_state == DONE);

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: if (start) begin
        w_accept    = 1'b1;
        w_state_nxt = (divisor == '0) ? DONE : RUN;
      end
      RUN:  if (w_last) w_state_nxt = DONE;
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_p         <= '0;
      r_q         <= '0;
      r_d         <= '0;
      r_cnt       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (w_accept) begin
      r_p   <= '0;
      r_q   <= dividend;
      r_d   <= divisor;
      r_cnt <= '0;
      // Zero divisor skips iteration and reports the saturated quotient immediately.
      if (divisor == '0) begin
        quotient    <= '1;
        remainder   <= dividend[WIDTH-1:0];
        div_by_zero <= 1'b1;
      end else begin
        quotient    <= '0;
        remainder   <= '0;
        div_by_zero <= 1'b0;
      end
    end else if (r_state == RUN) begin
      r_p   <= w_p_nxt;
      r_q   <= {r_q[QW-2:0], w_qbit};
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        quotient  <= {r_q[QW-2:0], w_qbit};
        remainder <= w_p_nxt[WIDTH-1:0];
      end
    end
  end
endmodule

// File: tb/tb_seq_div_48by24.sv
// Directed self-checking bench for seq_div_48by24.
module tb_seq_div_48by24;
  logic        clk, rst, start;
  logic [47:0] dividend;
  logic [23:0] divisor;
  logic [47:0] quotient;
  logic [23:0] remainder;
  logic        busy, done, div_by_zero;
  int          n_tests = 0;
  int          n_fail  = 0;

  seq_div_48by24 dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // k = number of edges after the accepting edge before done is seen; bc = busy cycles before done.
  task automatic run_chk(input string tag, input logic [47:0] a, input logic [23:0] b,
                         input int inj, input logic [47:0] eq, input logic [23:0] er,
                         input logic ez, input int ek, input int ebc);
    int k, bc;
    @(negedge clk); dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; dividend = ~a; divisor = ~b;
    @(negedge clk); k = 0; bc = 0;
    while (done !== 1'b1 && k < 200) begin
      if (busy) bc++;
      start = (k == inj);
      if (k == inj) begin dividend = 48'd50; divisor = 24'd5; end
      @(negedge clk); k++;
    end
    start = 1'b0;
    chk({tag, "_lat"}, k, ek);
    chk({tag, "_busycyc"}, bc, ebc);
    chk({tag, "_busy_at_done"}, busy, 0);
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    chk({tag, "_dbz"}, div_by_zero, ez);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_q_held"}, quotient, eq);
    chk({tag, "_dbz_held"}, div_by_zero, ez);
  endtask

  initial begin
    int npulse;
    rst = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dbz", div_by_zero, 0);
    rst = 1'b1;

    run_chk("d100_7", 48'd100, 24'd7, -1, 48'd14, 24'd2, 1'b0, 48, 48);
    run_chk("sq_max", 48'hFFFFFE000001, 24'hFFFFFF, -1, 48'h000000FFFFFF, 24'd0, 1'b0, 48, 48);
    run_chk("dbz", 48'h000000123456, 24'd0, -1, 48'hFFFFFFFFFFFF, 24'h123456, 1'b1, 0, 0);
    run_chk("ignored_start", 48'd8369910, 24'd678, 10, 48'd12345, 24'd0, 1'b0, 48, 48);
    run_chk("d50_5", 48'd50, 24'd5, -1, 48'd10, 24'd0, 1'b0, 48, 48);

    // Abort mid-operation with reset.
    @(negedge clk); dividend = 48'd100; divisor = 24'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_busy_before", busy, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_q", quotient, 0);
    chk("abort_r", remainder, 0);
    chk("abort_done", done, 0);
    rst = 1'b1;
    npulse = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) npulse++;
    end
    chk("abort_no_done", npulse, 0);
    run_chk("d9_2", 48'd9, 24'd2, -1, 48'd4, 24'd1, 1'b0, 48, 48);

    run_chk("rt_abcdef", 48'(24'hABCDEF) * 48'(24'h123456), 24'h123456, -1,
            48'hABCDEF, 24'd0, 1'b0, 48, 48);
    run_chk("max_by_1", 48'hFFFFFFFFFFFF, 24'd1, -1, 48'hFFFFFFFFFFFF, 24'd0, 1'b0, 48, 48);
    run_chk("max_by_max", 48'hFFFFFFFFFFFF, 24'hFFFFFF, -1, 48'h000001000001, 24'd0, 1'b0, 48, 48);
    run_chk("small_by_big", 48'd5, 24'd10, -1, 48'd0, 24'd5, 1'b0, 48, 48);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
